// File: rtl/layer_train_sequencer_pkg.sv
// Shared definitions for the layer training sequencer and the neuron layers
// it drives: FSM state encoding, field widths and fixed-point value types.
package layer_train_sequencer_pkg;

    localparam int EPOCH_W  = 8;
    localparam int SETTLE_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EVAL,
        S_SETTLE,
        S_LEARN,
        S_NEXT,
        S_DONE
    } seq_state_t;

    // Unsigned Q0.16 value in [0, 1), used for rates and activations.
    typedef logic [15:0] zero2one_t;

    // Signed Q1.15 value in [-1, 1), used for weights and errors.
    typedef logic signed [15:0] frac_t;

    // Width of a sample index; a single-sample run still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_train_sequencer_if.sv
// Handshake bundle between the training sequencer (master) and its
// controller / sample source (slave). busy_cycles exists only when
// LAYER_SEQ_PERF_CNT_EN is defined.
interface layer_train_sequencer_if #(
    parameter int IDX_W = 4
);
    import layer_train_sequencer_pkg::*;

    logic               start;
    logic               abort;
    logic               infer_only;
    logic               sample_req;
    logic [IDX_W-1:0]   sample_idx;
    logic               sample_ack;
    logic               layer_valid;
    logic               layer_learn;
    logic [EPOCH_W-1:0] epoch;
    logic               busy;
    logic               done;
`ifdef LAYER_SEQ_PERF_CNT_EN
    logic [31:0]        busy_cycles;

    modport master (
        input  start, abort, infer_only, sample_ack,
        output sample_req, sample_idx, layer_valid, layer_learn,
               epoch, busy, done, busy_cycles
    );

    modport slave (
        output start, abort, infer_only, sample_ack,
        input  sample_req, sample_idx, layer_valid, layer_learn,
               epoch, busy, done, busy_cycles
    );
`else
    modport master (
        input  start, abort, infer_only, sample_ack,
        output sample_req, sample_idx, layer_valid, layer_learn,
               epoch, busy, done
    );

    modport slave (
        output start, abort, infer_only, sample_ack,
        input  sample_req, sample_idx, layer_valid, layer_learn,
               epoch, busy, done
    );
`endif

endinterface

// File: rtl/layer_train_sequencer.sv
// Training sequencer: walks N_EPOCHS passes over N_SAMPLES samples, and for
// each sample fetches it, pulses layer_valid, waits SETTLE cycles, then
// pulses layer_learn (suppressed in inference-only runs).
// Optional feature macro: LAYER_SEQ_PERF_CNT_EN adds the busy_cycles counter.
module layer_train_sequencer
    import layer_train_sequencer_pkg::*;
#(
    parameter int N_SAMPLES = 16,
    parameter int N_EPOCHS  = 8,
    parameter int SETTLE    = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    layer_train_sequencer_if.master bus
);

    localparam int                  IDX_W       = idx_width(N_SAMPLES);
    localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(N_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0]  LAST_EPOCH  = EPOCH_W'(N_EPOCHS - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    seq_state_t          state_reg;
    logic [SETTLE_W-1:0] settle_cnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [EPOCH_W-1:0]  epoch_reg;
    logic                infer_reg;
    logic                sample_req_reg;
    logic                layer_valid_reg;
    logic                layer_learn_reg;
    logic                busy_reg;
    logic                done_reg;

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= S_IDLE;
            settle_cnt_reg  <= '0;
            idx_reg         <= '0;
            epoch_reg       <= '0;
            infer_reg       <= 1'b0;
            sample_req_reg  <= 1'b0;
            layer_valid_reg <= 1'b0;
            layer_learn_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            // valid, learn and done are single-cycle pulses.
            layer_valid_reg <= 1'b0;
            layer_learn_reg <= 1'b0;
            done_reg        <= 1'b0;

            if (state_reg != S_IDLE && bus.abort) begin
                // Abort wins over everything, including a same-cycle ack.
                state_reg      <= S_IDLE;
                sample_req_reg <= 1'b0;
                busy_reg       <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (bus.start) begin
                            idx_reg        <= '0;
                            epoch_reg      <= '0;
                            infer_reg      <= bus.infer_only;
                            sample_req_reg <= 1'b1;
                            busy_reg       <= 1'b1;
                            state_reg      <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (bus.sample_ack) begin
                            sample_req_reg  <= 1'b0;
                            layer_valid_reg <= 1'b1;
                            state_reg       <= S_EVAL;
                        end
                    end
                    S_EVAL: begin
                        if (SETTLE == 0) begin
                            layer_learn_reg <= !infer_reg;
                            state_reg       <= S_LEARN;
                        end else begin
                            settle_cnt_reg <= SETTLE_LOAD;
                            state_reg      <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt_reg == '0) begin
                            layer_learn_reg <= !infer_reg;
                            state_reg       <= S_LEARN;
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg - 1'b1;
                        end
                    end
                    S_LEARN: begin
                        state_reg <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (idx_reg == LAST_IDX) begin
                            idx_reg <= '0;
                            if (epoch_reg == LAST_EPOCH) begin
                                // Final epoch: epoch stays at its last value.
                                done_reg  <= 1'b1;
                                state_reg <= S_DONE;
                            end else begin
                                epoch_reg      <= epoch_reg + 1'b1;
                                sample_req_reg <= 1'b1;
                                state_reg      <= S_FETCH;
                            end
                        end else begin
                            idx_reg        <= idx_reg + 1'b1;
                            sample_req_reg <= 1'b1;
                            state_reg      <= S_FETCH;
                        end
                    end
                    S_DONE: begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                    default: begin
                        sample_req_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        state_reg      <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sample_req  = sample_req_reg;
    assign bus.sample_idx  = idx_reg;
    assign bus.layer_valid = layer_valid_reg;
    assign bus.layer_learn = layer_learn_reg;
    assign bus.epoch       = epoch_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;

`ifdef LAYER_SEQ_PERF_CNT_EN
    logic [31:0] busy_cycles_reg;

    // Saturating count of busy cycles, restarted by each accepted start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_cycles_reg <= '0;
        end else if (state_reg == S_IDLE && bus.start) begin
            busy_cycles_reg <= '0;
        end else if (busy_reg && busy_cycles_reg != 32'hFFFF_FFFF) begin
            busy_cycles_reg <= busy_cycles_reg + 32'd1;
        end
    end

    assign bus.busy_cycles = busy_cycles_reg;
`endif

endmodule

// File: tb/tb_layer_train_sequencer.sv
// Bench for layer_train_sequencer (N_SAMPLES=4, N_EPOCHS=2, SETTLE=2).
// A sample-position model predicts every output each cycle; directed runs
// add hand-computed expectations (pulse counts, latencies, abort/reset).
module tb_layer_train_sequencer;
    import layer_train_sequencer_pkg::*;

    localparam int NS = 4;
    localparam int NE = 2;
    localparam int ST = 2;
    localparam int IW = idx_width(NS);

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    layer_train_sequencer_if #(.IDX_W(IW)) bus();

    layer_train_sequencer #(
        .N_SAMPLES(NS),
        .N_EPOCHS (NE),
        .SETTLE   (ST)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc++;

    // ---------------- model: which sample, how far into it ----------------
    // Position within a sample: 0 fetch (held until ack), 1 valid,
    // 2..ST+1 settle, ST+2 learn, ST+3 advance to next sample.
    bit          m_active, m_infer, m_done;
    int          m_k, m_off, m_idx, m_epoch;
    logic [31:0] m_bc;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_infer = 0; m_done = 0;
            m_k = 0; m_off = 0; m_idx = 0; m_epoch = 0; m_bc = 0;
        end else begin
            if (m_active && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
            if (!m_active) begin
                if (bus.start) begin
                    m_active = 1; m_k = 0; m_off = 0; m_idx = 0; m_epoch = 0;
                    m_infer = bus.infer_only; m_bc = 0;
                end
            end else if (bus.abort || m_done) begin
                m_active = 0; m_done = 0;
            end else if (m_off == 0) begin
                if (bus.sample_ack) m_off = 1;
            end else if (m_off == ST + 3) begin
                m_k++; m_off = 0;
                if (m_k == NS * NE) begin
                    m_done = 1; m_idx = 0;
                end else begin
                    m_idx = m_k % NS; m_epoch = m_k / NS;
                end
            end else begin
                m_off++;
            end
        end
    end

    // ---------------- compare + event monitor ----------------
    int valid_cnt = 0, learn_cnt = 0, done_cnt = 0, last_valid_cyc = 0;
    int req2_cnt = 0, req2_last = 0, valid2_cyc = 0;

    always @(negedge clock) begin
        if (cmp_en) begin
            check("sample_req",  bus.sample_req,  m_active && !m_done && m_off == 0);
            check("layer_valid", bus.layer_valid, m_active && !m_done && m_off == 1);
            check("layer_learn", bus.layer_learn, m_active && !m_done && m_off == ST + 2 && !m_infer);
            check("busy",        bus.busy,        m_active);
            check("done",        bus.done,        m_done);
            check("sample_idx",  bus.sample_idx,  m_idx);
            check("epoch",       bus.epoch,       m_epoch);
            check("valid_learn_excl", bus.layer_valid & bus.layer_learn, 0);
`ifdef LAYER_SEQ_PERF_CNT_EN
            check("busy_cycles", bus.busy_cycles, m_bc);
`endif
            if (bus.layer_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                if (bus.sample_idx == 2 && bus.epoch == 0) valid2_cyc = cyc;
            end
            if (bus.layer_learn) begin
                learn_cnt++;
                check("learn_gap", cyc - last_valid_cyc, 3);
            end
            if (bus.done) done_cnt++;
            if (bus.sample_req && bus.sample_idx == 2 && bus.epoch == 0) begin
                req2_cnt++;
                req2_last = cyc;
            end
        end
    end

    // ---------------- sample source ----------------
    // mode 0: ack always; 1: hold off ack for 5 fetch cycles of sample 2,
    // epoch 0; 2: never ack.
    int ack_mode  = 0;
    int fetch2    = 0;
    always @(negedge clock) begin
        if (!bus.busy) fetch2 = 0;
        if (bus.sample_req && bus.sample_idx == 2 && bus.epoch == 0) fetch2++;
        case (ack_mode)
            1:       bus.sample_ack = !(bus.sample_req && bus.sample_idx == 2 &&
                                        bus.epoch == 0 && fetch2 < 6);
            2:       bus.sample_ack = 1'b0;
            default: bus.sample_ack = 1'b1;
        endcase
    end

    // ---------------- stimulus ----------------
    int start_cyc = 0;

    task automatic run_start(input bit infer);
        @(negedge clock);
        bus.infer_only = infer;
        bus.start      = 1'b1;
        start_cyc      = cyc;
        @(negedge clock);
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(output int dcyc, output bit got);
        got  = 0;
        dcyc = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clock);
            if (bus.done) begin
                got  = 1;
                dcyc = cyc;
            end
        end
        check("done_seen", got, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  dcyc;
        bit  got;
        bit  hit;
        int  bv, bl, bd, br;

        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.infer_only = 1'b0;
        bus.sample_ack = 1'b0;

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_req",   bus.sample_req,  0);
        check("rst_valid", bus.layer_valid, 0);
        check("rst_learn", bus.layer_learn, 0);
        check("rst_busy",  bus.busy,        0);
        check("rst_done",  bus.done,        0);
        check("rst_idx",   bus.sample_idx,  0);
        check("rst_epoch", bus.epoch,       0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        repeat (2) @(negedge clock);

        // Full training run with immediate ack.
        bv = valid_cnt; bl = learn_cnt;
        run_start(1'b0);
        wait_done(dcyc, got);
        check("run_done_latency", dcyc - start_cyc, 49);
        check("run_epoch_at_done", bus.epoch, 1);
        check("run_idx_at_done", bus.sample_idx, 0);
        check("run_valid_count", valid_cnt - bv, 8);
        check("run_learn_count", learn_cnt - bl, 8);
        @(negedge clock);
        check("run_idle_after_done", bus.busy, 0);
`ifdef LAYER_SEQ_PERF_CNT_EN
        check("run_busy_cycles", bus.busy_cycles, 49);
`endif

        // Inference-only run: no learn pulses, done still raised.
        bv = valid_cnt; bl = learn_cnt;
        run_start(1'b1);
        bus.infer_only = 1'b0;
        wait_done(dcyc, got);
        check("infer_valid_count", valid_cnt - bv, 8);
        check("infer_learn_count", learn_cnt - bl, 0);
        check("infer_done_latency", dcyc - start_cyc, 49);

        // Delayed ack on sample 2.
        repeat (2) @(negedge clock);
        ack_mode = 1;
        br = req2_cnt;
        run_start(1'b0);
        wait_done(dcyc, got);
        check("delay_req_cycles", req2_cnt - br, 6);
        check("delay_valid_after_ack", valid2_cyc - req2_last, 1);
        check("delay_done_latency", dcyc - start_cyc, 54);
        ack_mode = 0;

        // Abort during SETTLE of sample 1, epoch 0.
        repeat (2) @(negedge clock);
        run_start(1'b0);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clock);
            if (bus.layer_valid && bus.sample_idx == 1 && bus.epoch == 0) hit = 1;
        end
        check("abort_armed", hit, 1);
        @(negedge clock);
        bus.abort = 1'b1;
        bl = learn_cnt; bd = done_cnt;
        @(negedge clock);
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_req", bus.sample_req, 0);
        repeat (5) @(negedge clock);
        check("abort_no_learn", learn_cnt - bl, 0);
        check("abort_no_done", done_cnt - bd, 0);
        run_start(1'b0);
        check("restart_req", bus.sample_req, 1);
        check("restart_idx", bus.sample_idx, 0);
        check("restart_epoch", bus.epoch, 0);
        wait_done(dcyc, got);
        check("restart_done_latency", dcyc - start_cyc, 49);

        // Asynchronous reset in the middle of FETCH.
        repeat (2) @(negedge clock);
        ack_mode = 2;
        run_start(1'b0);
        repeat (2) @(negedge clock);
        check("prerst_req", bus.sample_req, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_req",  bus.sample_req,  0);
        check("async_rst_busy", bus.busy,        0);
        check("async_rst_valid", bus.layer_valid, 0);
        check("async_rst_learn", bus.layer_learn, 0);
        @(negedge clock);
        reset_n  = 1'b1;
        ack_mode = 0;
        repeat (3) @(negedge clock);
        check("post_rst_idle", bus.busy, 0);

        // Second start while busy must not disturb the run.
        bl = learn_cnt;
        run_start(1'b0);
        repeat (10) @(negedge clock);
        bus.infer_only = 1'b1;
        bus.start      = 1'b1;
        @(negedge clock);
        bus.start      = 1'b0;
        bus.infer_only = 1'b0;
        wait_done(dcyc, got);
        check("busy_start_done_latency", dcyc - start_cyc, 49);
        check("busy_start_learn_count", learn_cnt - bl, 8);

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
